// File: rtl/fifo_search_pkg.sv
// Shared types and default widths for the word-FIFO search path.
package fifo_search_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int DATA_W_DEF    = 32;
    localparam int LEN_W_DEF     = 16;
    localparam int TIMEOUT_W_DEF = 8;

endpackage

// File: rtl/masked_word_cmp.sv
// Combinational masked equality: a word matches when every bit selected by mask equals the key.
module masked_word_cmp
    import fifo_search_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] i_word,
    input  logic [DATA_W-1:0] i_key,
    input  logic [DATA_W-1:0] i_mask,
    output logic              o_match
);

    // An all-zero mask deliberately matches every word.
    assign o_match = ((i_word ^ i_key) & i_mask) == '0;

endmodule

// File: rtl/fifo_search_matcher.sv
// Drains LEN words from the word FIFO and reports masked-key match statistics.
// Optional stall timeout is compiled in with `define SEARCH_TIMEOUT_EN.
module fifo_search_matcher
    import fifo_search_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
`ifdef SEARCH_TIMEOUT_EN
    ,
    parameter int TIMEOUT_W = TIMEOUT_W_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] key,
    input  logic [DATA_W-1:0] mask,
    input  logic [LEN_W-1:0]  len,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [LEN_W-1:0]  first_idx,
    output logic [LEN_W-1:0]  match_cnt,
    output logic              timed_out
);

    state_t            r_state;
    logic [DATA_W-1:0] r_key;
    logic [DATA_W-1:0] r_mask;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_rcvd_cnt;
    logic [LEN_W-1:0]  r_first_idx;
    logic [LEN_W-1:0]  r_match_cnt;
    logic              r_rd_pend;
    logic              r_busy;
    logic              r_done;
    logic              r_found;
    logic              r_timed_out;

    logic [LEN_W:0]    w_issued;
    logic [LEN_W-1:0]  w_rcvd_nxt;
    logic              w_rd_en;
    logic              w_consume;
    logic              w_match;
    logic              w_last;
    logic              w_timeout;

    // Words received plus the one read in flight must never exceed len.
    assign w_issued   = {1'b0, r_rcvd_cnt} + {{LEN_W{1'b0}}, r_rd_pend};
    assign w_rd_en    = (r_state == SEARCH) && (w_issued < {1'b0, r_len});
    assign w_consume  = (r_state == SEARCH) && r_rd_pend && !fifo_empty;
    assign w_rcvd_nxt = r_rcvd_cnt + LEN_W'(1);
    assign w_last     = (w_rcvd_nxt == r_len);

    masked_word_cmp #(
        .DATA_W(DATA_W)
    ) u_cmp (
        .i_word (fifo_data),
        .i_key  (r_key),
        .i_mask (r_mask),
        .o_match(w_match)
    );

`ifdef SEARCH_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_stall_cnt;
    logic [TIMEOUT_W-1:0] w_stall_nxt;

    assign w_stall_nxt = r_stall_cnt + TIMEOUT_W'(1);
    assign w_timeout   = (r_state == SEARCH) && !w_consume && (w_stall_nxt == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (r_state == IDLE && start) begin
            r_stall_cnt <= '0;
        end else if (r_state == SEARCH) begin
            r_stall_cnt <= w_consume ? '0 : w_stall_nxt;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // NOTE: every register here uses <= so all state updates see the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_key       <= '0;
            r_mask      <= '0;
            r_len       <= '0;
            r_rcvd_cnt  <= '0;
            r_rd_pend   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_found     <= 1'b0;
            r_first_idx <= '0;
            r_match_cnt <= '0;
            r_timed_out <= 1'b0;
        end else begin
            r_rd_pend <= w_rd_en;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_key       <= key;
                        r_mask      <= mask;
                        r_len       <= len;
                        r_rcvd_cnt  <= '0;
                        r_found     <= 1'b0;
                        r_first_idx <= '0;
                        r_match_cnt <= '0;
                        r_timed_out <= 1'b0;
                        r_busy      <= 1'b1;
                        if (len == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= SEARCH;
                        end
                    end
                end
                SEARCH: begin
                    if (w_consume) begin
                        r_rcvd_cnt <= w_rcvd_nxt;
                        if (w_match) begin
                            if (r_match_cnt != '1) begin
                                r_match_cnt <= r_match_cnt + LEN_W'(1);
                            end
                            if (!r_found) begin
                                r_found     <= 1'b1;
                                r_first_idx <= r_rcvd_cnt;
                            end
                        end
                        if (w_last) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state     <= DONE;
                        r_done      <= 1'b1;
                        r_timed_out <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rd_en = w_rd_en;
    assign busy       = r_busy;
    assign done       = r_done;
    assign found      = r_found;
    assign first_idx  = r_first_idx;
    assign match_cnt  = r_match_cnt;
    assign timed_out  = r_timed_out;

endmodule

// File: tb/tb_fifo_search_matcher.sv
// Scoreboard bench for fifo_search_matcher with a registered word-FIFO model on the read side.
module tb_fifo_search_matcher;

    typedef struct {
        logic        found;
        logic [15:0] first_idx;
        logic [15:0] match_cnt;
        logic        timed_out;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] key = '0;
    logic [31:0] mask = '0;
    logic [15:0] len = '0;
    logic        fifo_rd_en;
    logic [31:0] fifo_data = '0;
    logic        fifo_empty = 1'b1;
    logic        busy;
    logic        done;
    logic        found;
    logic [15:0] first_idx;
    logic [15:0] match_cnt;
    logic        timed_out;

    logic [31:0] fifo_q[$];
    exp_t        exp_q[$];
    int          cyc = 0;
    int          pops = 0;
    int          rd_seen = 0;
    int          n_done = 0;
    int          done_cyc = 0;
    int          c0 = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    fifo_search_matcher #(
        .DATA_W(32),
        .LEN_W (16)
`ifdef SEARCH_TIMEOUT_EN
        ,
        .TIMEOUT_W(4)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key       (key),
        .mask      (mask),
        .len       (len),
        .fifo_rd_en(fifo_rd_en),
        .fifo_data (fifo_data),
        .fifo_empty(fifo_empty),
        .busy      (busy),
        .done      (done),
        .found     (found),
        .first_idx (first_idx),
        .match_cnt (match_cnt),
        .timed_out (timed_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered FIFO: empty flag reflects only the outcome of the last read request.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fifo_q.size() > 0) begin
                fifo_data  <= fifo_q.pop_front();
                fifo_empty <= 1'b0;
                pops++;
            end else begin
                fifo_empty <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && fifo_rd_en) rd_seen++;
        if (!rst && done) begin
            exp_t e;
            n_done++;
            done_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("found", {31'd0, found}, {31'd0, e.found});
                check("first_idx", {16'd0, first_idx}, {16'd0, e.first_idx});
                check("match_cnt", {16'd0, match_cnt}, {16'd0, e.match_cnt});
                check("timed_out", {31'd0, timed_out}, {31'd0, e.timed_out});
            end
        end
    end

    task automatic expect_result(input logic f, input logic [15:0] fi, input logic [15:0] mc,
                                 input logic to);
        exp_t e;
        e.found = f;
        e.first_idx = fi;
        e.match_cnt = mc;
        e.timed_out = to;
        exp_q.push_back(e);
    endtask

    task automatic do_start(input logic [31:0] k, input logic [31:0] m, input logic [15:0] l);
        @(negedge clk);
        key = k;
        mask = m;
        len = l;
        start = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int  base;
        bit  seen;
        base = n_done;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            #1;
            if (n_done != base) seen = 1'b1;
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_found", {31'd0, found}, 32'd0);
        check("rst_first_idx", {16'd0, first_idx}, 32'd0);
        check("rst_match_cnt", {16'd0, match_cnt}, 32'd0);
        check("rst_timed_out", {31'd0, timed_out}, 32'd0);
        check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Exact key: 0x10 matches words 0 and 2; done lands 5 edges after start.
        p0 = pops;
        fifo_q = '{32'h10, 32'h22, 32'h10, 32'h33};
        expect_result(1'b1, 16'd0, 16'd2, 1'b0);
        do_start(32'h10, 32'hFFFF_FFFF, 16'd4);
        check("t1_busy", {31'd0, busy}, 32'd1);
        wait_done(20, "t1_done_seen");
        check("t1_latency", done_cyc - c0, 32'd5);
        check("t1_pops", pops - p0, 32'd4);

        // Low-nibble mask: only 0x22 has nibble 2.
        fifo_q = '{32'h10, 32'h22, 32'h10, 32'h33};
        expect_result(1'b1, 16'd1, 16'd1, 1'b0);
        do_start(32'h2, 32'h0000_000F, 16'd4);
        wait_done(20, "t2_done_seen");
        check("t2_latency", done_cyc - c0, 32'd5);
        repeat (3) @(negedge clk);
        check("t2_hold_found", {31'd0, found}, 32'd1);
        check("t2_hold_match_cnt", {16'd0, match_cnt}, 32'd1);

        // Starved FIFO: failed reads retry; a word pushed after the third stays put.
        p0 = pops;
        expect_result(1'b1, 16'd0, 16'd2, 1'b0);
        do_start(32'hA, 32'hFFFF_FFFF, 16'd3);
        repeat (5) @(negedge clk);
        fifo_q.push_back(32'hA);
        repeat (5) @(negedge clk);
        fifo_q.push_back(32'hB);
        repeat (5) @(negedge clk);
        fifo_q.push_back(32'hA);
        @(negedge clk);
        fifo_q.push_back(32'hDD);
        wait_done(20, "t3_done_seen");
        repeat (4) @(negedge clk);
        check("t3_pops", pops - p0, 32'd3);
        check("t3_fifo_left", fifo_q.size(), 32'd1);

        // Zero length: immediate done with cleared results, no reads.
        rd_seen = 0;
        expect_result(1'b0, 16'd0, 16'd0, 1'b0);
        do_start(32'hA, 32'hFFFF_FFFF, 16'd0);
        wait_done(5, "t4_done_seen");
        check("t4_latency", done_cyc - c0, 32'd0);
        check("t4_rd_seen", rd_seen, 32'd0);
        check("t4_fifo_left", fifo_q.size(), 32'd1);

        // Reset after two consumed words; the in-flight third word is lost.
        fifo_q.delete();
        fifo_q = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h4};
        p0 = pops;
        do_start(32'h2, 32'hFFFF_FFFF, 16'd5);
        repeat (3) @(posedge clk);
        #1;
        check("t5_pre_found", {31'd0, found}, 32'd1);
        check("t5_pre_pops", pops - p0, 32'd3);
        rst = 1'b1;
        #1;
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_found", {31'd0, found}, 32'd0);
        check("t5_rst_match_cnt", {16'd0, match_cnt}, 32'd0);
        check("t5_rst_first_idx", {16'd0, first_idx}, 32'd0);
        check("t5_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        expect_result(1'b1, 16'd0, 16'd2, 1'b0);
        do_start(32'h4, 32'hFFFF_FFFF, 16'd3);
        @(negedge clk);
        key = 32'h5;
        len = 16'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(20, "t5_done_seen");
        repeat (3) @(negedge clk);
        check("t5_pops", pops - p0, 32'd6);
        check("t5_fifo_left", fifo_q.size(), 32'd0);

`ifdef SEARCH_TIMEOUT_EN
        // One word then starvation: 15 stalled edges after the consume at E2.
        fifo_q.delete();
        fifo_q.push_back(32'h7);
        expect_result(1'b1, 16'd0, 16'd1, 1'b1);
        do_start(32'h7, 32'hFFFF_FFFF, 16'd2);
        wait_done(40, "t6_done_seen");
        check("t6_latency", done_cyc - c0, 32'd17);
`endif

        check("exp_q_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_search_matcher.md
Name: fifo_search_matcher

Overview:
- Downstream consumer of the 32-bit word FIFO in the search path.
- On a start command, drains exactly LEN words from the FIFO read port and compares each word against a latched key under a latched bit mask.
- Reports match count, index of the first match and a found flag, then pulses done.
- Sits between the word FIFO and the search-result collector.

Parameters:
DATA_W, 32, word width; equals the FIFO data width
LEN_W, 16, width of the length, index and count fields
TIMEOUT_W, 8, width of the stall-timeout counter (used only when the optional feature is compiled in)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle command pulse; honoured only in IDLE
key  input  DATA_W  search key; sampled when start is accepted
mask  input  DATA_W  compare mask, 1 = bit compared; sampled with start
len  input  LEN_W  number of words to consume; sampled with start
fifo_rd_en  output  1  read request to the FIFO
fifo_data  input  DATA_W  registered FIFO data out
fifo_empty  input  1  registered FIFO empty flag; updates only on cycles following rd_en
busy  output  1  high in SEARCH and DONE
done  output  1  one-cycle pulse when the search completes
found  output  1  at least one match in this search
first_idx  output  LEN_W  index (0-based) of the first matching word
match_cnt  output  LEN_W  number of matching words
timed_out  output  1  search ended by timeout (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (async): state IDLE; rd_pend=0; all counters 0; fifo_rd_en=0, busy=0, done=0, found=0, first_idx=0, match_cnt=0, timed_out=0.
- States:
  - IDLE -> SEARCH on start when len != 0. The start edge latches key, mask and len, and clears found, first_idx, match_cnt and timed_out.
  - IDLE -> DONE on start when len == 0. Results are cleared; no FIFO reads are issued.
  - SEARCH -> DONE on the edge that consumes word len-1.
  - DONE -> IDLE unconditionally after one cycle.
- start outside IDLE: ignored; latched values are unchanged.
- Read protocol:
  - fifo_rd_en = (state==SEARCH) && (rcvd_cnt + rd_pend < len_q). This is combinational from registers.
  - rd_pend is a register loaded with fifo_rd_en every edge.
  - A word is consumed on an edge where rd_pend=1 and fifo_empty=0; rcvd_cnt then increments.
  - rd_pend=1 with fifo_empty=1 is a failed read. The FIFO pointer does not advance, nothing is consumed, and the read is reissued automatically because rcvd_cnt is unchanged.
  - A maximum of one read is outstanding. The block never reads more than len words, including when the last read fails.
  - Throughput is 1 word/cycle while the FIFO is non-empty.
- Compare:
  - A consumed word matches if ((fifo_data ^ key_q) & mask_q) == 0.
  - mask_q == 0 matches every word.
- Result update on a consumed matching word:
  - match_cnt increments (saturates at all-ones).
  - If found==0: found<=1 and first_idx<=rcvd_cnt.
- Outputs:
  - Results are registered and held stable from done until the next accepted start.
  - done is high for exactly the DONE cycle.
- Latency: with start sampled at edge E0 and the FIFO never empty, word k is consumed at edge E(k+2), and done is high in the cycle after E(len+1). Each failed read adds one cycle.
- Reset mid-search: abandons immediately. Any word already popped by the FIFO is discarded and not re-requested.

Optional Feature:
- Macro: SEARCH_TIMEOUT_EN.
- Defined:
  - A stall counter (TIMEOUT_W bits) increments each SEARCH cycle with no consumed word and clears on every consumed word and on start.
  - When the counter reaches all-ones, the state goes SEARCH -> DONE and timed_out<=1. Partial results are retained.
  - fifo_rd_en drops with the state change. An in-flight read is still sampled one last time in DONE and then ignored.
- Undefined: no counter; SEARCH waits indefinitely for words; timed_out is constant 0.

Decomposition:
- Shared package fifo_search_pkg:
  - state enum {IDLE, SEARCH, DONE}
  - DATA_W and LEN_W defaults
  - TIMEOUT_W default
- Sub-module masked_word_cmp: combinational DATA_W masked-equality compare, reusable by later search stages.
- The FSM, counters and result registers stay in the top.

Test Plan:
1. FIFO preloaded with 0x10,0x22,0x10,0x33; start key=0x10, mask=0xFFFFFFFF, len=4 -> four reads back-to-back; done in the cycle after E5; found=1, first_idx=0, match_cnt=2.
2. Same data, key=0x00000002, mask=0x0000000F, len=4 -> found=1, first_idx=1, match_cnt=1.
3. FIFO empty at start, len=3, words pushed at 5-cycle gaps -> failed reads reissue; exactly 3 words are popped, and a 4th word pushed later remains in the FIFO.
4. start with len=0 -> done in the cycle after the start edge; fifo_rd_en never high; found=0, match_cnt=0.
5. rst asserted after 2 of 5 words are consumed -> all outputs are 0 immediately; a new start with len=3 reads the next FIFO words; a start pulse during busy is ignored.
6. (SEARCH_TIMEOUT_EN, TIMEOUT_W=4) len=2, one word supplied then the FIFO is starved -> done after a 15-cycle stall; timed_out=1, match_cnt reflects the single consumed word.
